// File: rtl/led_chaser_pkg.sv
// Shared types and helpers for the running-light generator (led_chaser_n).
package led_chaser_pkg;

  typedef enum logic [1:0] {INIT, RUN, FLASH} state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Step period for a speed level: slower levels repeat the base interval.
  function automatic logic [31:0] calc_period(input logic [31:0] base_ticks,
                                              input logic [31:0] speed_lvl);
    return base_ticks * (speed_lvl + 32'd1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low button front end: 2-flop sync, optional debounce (LED_CHASER_DEBOUNCE_EN),
// and a one-cycle press pulse on the released->pressed transition of the filtered level.
module btn_debounce #(
  parameter int DB_TICKS = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_press;
  logic w_level;

  if (DB_TICKS < 1) begin : g_db_chk
    $error("btn_debounce: DB_TICKS must be >= 1");
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
    end
  end

`ifdef LED_CHASER_DEBOUNCE_EN
  localparam int CW = $clog2(DB_TICKS + 1);

  logic [CW-1:0] r_cnt;
  logic          r_stable;

  // The filtered level only follows after DB_TICKS consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DB_TICKS - 1)) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_level = r_stable;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev  <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_prev  <= w_level;
      r_press <= r_prev & ~w_level;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_chaser_n.sv
// N-wide active-low running light with speed ladder, wrap/ping-pong motion and a flash on direction change.
// Buttons pass through btn_debounce; LED_CHASER_DEBOUNCE_EN adds the debounce filter.
module led_chaser_n
  import led_chaser_pkg::*;
#(
  parameter int N_LED        = 4,
  parameter int SPEED_LEVELS = 4,
  parameter int BASE_TICKS   = 25_000_000,
  parameter int FLASH_TICKS  = 12_500_000,
  parameter int DB_TICKS     = 1_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_dir,
  input  logic                btn_speed,
  input  logic                bounce,
  output logic [N_LED-1:0]    led,
  output logic [$clog2(N_LED)-1:0] pos,
  output logic                dir,
  output logic [((SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1)-1:0] speed
);

  localparam int PW = $clog2(N_LED);
  localparam int SW = (SPEED_LEVELS > 1) ? $clog2(SPEED_LEVELS) : 1;
  localparam logic [PW-1:0] POS_LAST   = PW'(N_LED - 1);
  localparam logic [SW-1:0] SPD_LAST   = SW'(SPEED_LEVELS - 1);
  localparam logic [31:0]   FLASH_LAST = 32'(FLASH_TICKS - 1);

  if (N_LED < 2 || SPEED_LEVELS < 1 || BASE_TICKS < 2 || FLASH_TICKS < 1 ||
      (64'(BASE_TICKS) * 64'(SPEED_LEVELS)) >= 64'h1_0000_0000) begin : g_param_chk
    $error("led_chaser_n: illegal parameters (BASE_TICKS*SPEED_LEVELS must fit in 32 bits)");
  end

  state_t          r_state, w_state_nxt;
  logic [N_LED-1:0] r_led, w_led_nxt;
  logic [PW-1:0]   r_pos, w_pos_nxt, w_step_pos;
  logic            r_dir, w_dir_nxt, w_step_dir;
  logic [SW-1:0]   r_speed, w_speed_nxt, w_speed_inc;
  logic [31:0]     r_tick, w_tick_nxt;
  logic [31:0]     r_flash, w_flash_nxt;
  logic [31:0]     w_period;
  logic            w_dir_press;
  logic            w_speed_press;

  btn_debounce #(.DB_TICKS(DB_TICKS)) u_btn_dir (
    .clk     (clk),
    .reset   (reset),
    .i_btn_n (btn_dir),
    .o_press (w_dir_press)
  );

  btn_debounce #(.DB_TICKS(DB_TICKS)) u_btn_speed (
    .clk     (clk),
    .reset   (reset),
    .i_btn_n (btn_speed),
    .o_press (w_speed_press)
  );

  assign w_period    = calc_period(32'(BASE_TICKS), 32'(r_speed));
  assign w_speed_inc = (r_speed == SPD_LAST) ? '0 : r_speed + SW'(1);

  // Ping-pong turns around at an end and moves inward so no LED repeats.
  always_comb begin
    w_step_pos = r_pos;
    w_step_dir = r_dir;
    if (r_dir == DIR_UP) begin
      if (r_pos == POS_LAST) begin
        if (bounce) begin
          w_step_pos = POS_LAST - PW'(1);
          w_step_dir = DIR_DOWN;
        end else begin
          w_step_pos = '0;
        end
      end else begin
        w_step_pos = r_pos + PW'(1);
      end
    end else begin
      if (r_pos == '0) begin
        if (bounce) begin
          w_step_pos = PW'(1);
          w_step_dir = DIR_UP;
        end else begin
          w_step_pos = POS_LAST;
        end
      end else begin
        w_step_pos = r_pos - PW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_led_nxt   = r_led;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_speed_nxt = r_speed;
    w_tick_nxt  = r_tick;
    w_flash_nxt = r_flash;
    case (r_state)
      INIT: begin
        w_state_nxt = RUN;
        w_led_nxt   = ~(N_LED'(1) << r_pos);
        w_tick_nxt  = '0;
      end
      RUN: begin
        // A direction press discards any step falling due in the same cycle.
        if (w_dir_press) begin
          w_dir_nxt   = ~r_dir;
          w_tick_nxt  = '0;
          w_state_nxt = FLASH;
          w_led_nxt   = '0;
          w_flash_nxt = '0;
        end else if (r_tick == w_period - 32'd1) begin
          w_tick_nxt = '0;
          w_pos_nxt  = w_step_pos;
          w_dir_nxt  = w_step_dir;
          w_led_nxt  = ~(N_LED'(1) << w_step_pos);
        end else begin
          w_tick_nxt = r_tick + 32'd1;
        end
        if (w_speed_press) begin
          w_speed_nxt = w_speed_inc;
          w_tick_nxt  = '0;
        end
      end
      FLASH: begin
        if (r_flash == FLASH_LAST) begin
          w_state_nxt = RUN;
          w_led_nxt   = ~(N_LED'(1) << r_pos);
          w_tick_nxt  = '0;
        end else begin
          w_flash_nxt = r_flash + 32'd1;
        end
        if (w_speed_press) begin
          w_speed_nxt = w_speed_inc;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_led_nxt   = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= INIT;
      r_led   <= '1;
      r_pos   <= '0;
      r_dir   <= DIR_UP;
      r_speed <= '0;
      r_tick  <= '0;
      r_flash <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_pos   <= w_pos_nxt;
      r_dir   <= w_dir_nxt;
      r_speed <= w_speed_nxt;
      r_tick  <= w_tick_nxt;
      r_flash <= w_flash_nxt;
    end
  end

  assign led   = r_led;
  assign pos   = r_pos;
  assign dir   = r_dir;
  assign speed = r_speed;

endmodule

// File: tb/tb_led_chaser_n.sv
// Scoreboard bench for led_chaser_n (N_LED=4, BASE_TICKS=4, FLASH_TICKS=2, DB_TICKS=3, SPEED_LEVELS=4).
module tb_led_chaser_n;

  localparam int R = 3;  // cycle at which reset is released
`ifdef LED_CHASER_DEBOUNCE_EN
  localparam int BL      = 6;  // first low sample to press-pulse, in edges
  localparam int END_CYC = R + 214;
`else
  localparam int BL      = 3;
  localparam int END_CYC = R + 192;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_dir;
  logic       btn_speed;
  logic       bounce;
  logic [3:0] led;
  logic [1:0] pos;
  logic       dir;
  logic [1:0] speed;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic [1:0] pos;
    logic       dir;
    logic [1:0] spd;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  led_chaser_n #(
    .N_LED        (4),
    .SPEED_LEVELS (4),
    .BASE_TICKS   (4),
    .FLASH_TICKS  (2),
    .DB_TICKS     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_dir   (btn_dir),
    .btn_speed (btn_speed),
    .bounce    (bounce),
    .led       (led),
    .pos       (pos),
    .dir       (dir),
    .speed     (speed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input logic [3:0] l, input logic [1:0] p,
                           input logic d, input logic [1:0] s);
    exp_t e;
    e.cyc = c; e.led = l; e.pos = p; e.dir = d; e.spd = s;
    q.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every visible output change is one event, matched against the queue head.
  logic       have_prev = 1'b0;
  logic [6:0] prev;
  always @(negedge clk) begin
    logic [6:0] cur;
    exp_t       e;
    cur = {led, pos, dir, speed};
    if (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_event: no change seen by cycle %0d, required led=%b pos=%0d dir=%0b speed=%0d at cycle %0d",
               cyc, e.led, e.pos, e.dir, e.spd, e.cyc);
    end
    if (!have_prev || cur != prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cycle %0d led=%b pos=%0d dir=%0b speed=%0d, required no change",
                 cyc, led, pos, dir, speed);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || led != e.led || pos != e.pos || dir != e.dir || speed != e.spd) begin
          errors++;
          $display("FAIL event_c%0d: got cycle %0d led=%b pos=%0d dir=%0b speed=%0d, required cycle %0d led=%b pos=%0d dir=%0b speed=%0d",
                   e.cyc, cyc, led, pos, dir, speed, e.cyc, e.led, e.pos, e.dir, e.spd);
        end
      end
    end
    prev      = cur;
    have_prev = 1'b1;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d, required end by cycle %0d", cyc, END_CYC);
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    btn_dir   = 1'b1;
    btn_speed = 1'b1;
    bounce    = 1'b0;

    // Reset state, INIT cycle, then wrap-mode stepping every 4 cycles.
    expect_ev(1,      4'b1111, 2'd0, 1'b0, 2'd0);
    expect_ev(R + 1,  4'b1110, 2'd0, 1'b0, 2'd0);
    expect_ev(R + 5,  4'b1101, 2'd1, 1'b0, 2'd0);
    expect_ev(R + 9,  4'b1011, 2'd2, 1'b0, 2'd0);
    expect_ev(R + 13, 4'b0111, 2'd3, 1'b0, 2'd0);
    expect_ev(R + 17, 4'b1110, 2'd0, 1'b0, 2'd0);
    at_cyc(R);
    reset = 1'b1;

    // Ping-pong motion.
    at_cyc(R + 17);
    bounce = 1'b1;
    expect_ev(R + 21, 4'b1101, 2'd1, 1'b0, 2'd0);
    expect_ev(R + 25, 4'b1011, 2'd2, 1'b0, 2'd0);
    expect_ev(R + 29, 4'b0111, 2'd3, 1'b0, 2'd0);
    expect_ev(R + 33, 4'b1011, 2'd2, 1'b1, 2'd0);
    expect_ev(R + 37, 4'b1101, 2'd1, 1'b1, 2'd0);
    expect_ev(R + 41, 4'b1110, 2'd0, 1'b1, 2'd0);
    expect_ev(R + 45, 4'b1101, 2'd1, 1'b0, 2'd0);
    expect_ev(R + 49, 4'b1011, 2'd2, 1'b0, 2'd0);

    // Dir press at pos 2: pulse lands on a due step, which is dropped; 2-cycle flash.
    at_cyc(R + 53 - 1 - BL);
    expect_ev(R + 53, 4'b0000, 2'd2, 1'b1, 2'd0);
    expect_ev(R + 55, 4'b1011, 2'd2, 1'b1, 2'd0);
    expect_ev(R + 59, 4'b1101, 2'd1, 1'b1, 2'd0);
    expect_ev(R + 63, 4'b1110, 2'd0, 1'b1, 2'd0);
    expect_ev(R + 67, 4'b1101, 2'd1, 1'b0, 2'd0);
    btn_dir = 1'b0;
    at_cyc(R + 60);
    btn_dir = 1'b1;

    // Speed ladder; first press held 50 cycles gives a single increment.
    at_cyc(R + 72 - 1 - BL);
    expect_ev(R + 71,  4'b1011, 2'd2, 1'b0, 2'd0);
    expect_ev(R + 72,  4'b1011, 2'd2, 1'b0, 2'd1);
    expect_ev(R + 80,  4'b0111, 2'd3, 1'b0, 2'd1);
    expect_ev(R + 88,  4'b1011, 2'd2, 1'b1, 2'd1);
    expect_ev(R + 96,  4'b1101, 2'd1, 1'b1, 2'd1);
    expect_ev(R + 104, 4'b1110, 2'd0, 1'b1, 2'd1);
    expect_ev(R + 112, 4'b1101, 2'd1, 1'b0, 2'd1);
    expect_ev(R + 120, 4'b1011, 2'd2, 1'b0, 2'd1);
    btn_speed = 1'b0;
    at_cyc(R + 72 - 1 - BL + 50);
    btn_speed = 1'b1;

    at_cyc(R + 125 - 1 - BL);
    expect_ev(R + 125, 4'b1011, 2'd2, 1'b0, 2'd2);
    expect_ev(R + 137, 4'b0111, 2'd3, 1'b0, 2'd2);
    btn_speed = 1'b0;
    at_cyc(R + 125 - 1 - BL + 5);
    btn_speed = 1'b1;

    at_cyc(R + 145 - 1 - BL);
    expect_ev(R + 145, 4'b0111, 2'd3, 1'b0, 2'd3);
    expect_ev(R + 161, 4'b1011, 2'd2, 1'b1, 2'd3);
    btn_speed = 1'b0;
    at_cyc(R + 145 - 1 - BL + 5);
    btn_speed = 1'b1;

    at_cyc(R + 165 - 1 - BL);
    expect_ev(R + 165, 4'b1011, 2'd2, 1'b1, 2'd0);
    expect_ev(R + 169, 4'b1101, 2'd1, 1'b1, 2'd0);
    expect_ev(R + 173, 4'b1110, 2'd0, 1'b1, 2'd0);
    expect_ev(R + 177, 4'b1101, 2'd1, 1'b0, 2'd0);
    btn_speed = 1'b0;
    at_cyc(R + 165 - 1 - BL + 5);
    btn_speed = 1'b1;

    // Simultaneous dir+speed press, then reset during FLASH.
    at_cyc(R + 182 - 1 - BL);
    expect_ev(R + 181, 4'b1011, 2'd2, 1'b0, 2'd0);
    expect_ev(R + 182, 4'b0000, 2'd2, 1'b1, 2'd1);
    expect_ev(R + 183, 4'b1111, 2'd0, 1'b0, 2'd0);
    expect_ev(R + 186, 4'b1110, 2'd0, 1'b0, 2'd0);
    expect_ev(R + 190, 4'b1101, 2'd1, 1'b0, 2'd0);
    btn_dir   = 1'b0;
    btn_speed = 1'b0;
    at_cyc(R + 182);
    reset = 1'b0;
    at_cyc(R + 183);
    btn_dir   = 1'b1;
    btn_speed = 1'b1;
    at_cyc(R + 185);
    reset = 1'b1;

`ifdef LED_CHASER_DEBOUNCE_EN
    // 2-cycle glitch is filtered; a 10-cycle press increments 6 cycles after the first low sample.
    at_cyc(R + 190);
    expect_ev(R + 194, 4'b1011, 2'd2, 1'b0, 2'd0);
    expect_ev(R + 198, 4'b0111, 2'd3, 1'b0, 2'd0);
    expect_ev(R + 202, 4'b1011, 2'd2, 1'b1, 2'd0);
    expect_ev(R + 203, 4'b1011, 2'd2, 1'b1, 2'd1);
    expect_ev(R + 211, 4'b1101, 2'd1, 1'b1, 2'd1);
    btn_speed = 1'b0;
    at_cyc(R + 192);
    btn_speed = 1'b1;
    at_cyc(R + 196);
    btn_speed = 1'b0;
    at_cyc(R + 206);
    btn_speed = 1'b1;
`endif

    at_cyc(END_CYC);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected events never seen, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_chaser_n.md
# led_chaser_n

Parametrised running-light generator driving an N-wide active-low LED bank from two active-low push buttons. It is the next generation of the board's 4-LED chaser, adding:
- arbitrary LED count;
- a table-free speed ladder;
- wrap or ping-pong motion;
- edge-detected (optionally debounced) buttons;
- status outputs.

It sits directly behind the board button/LED pins of the demo top level.

## Interface
- N_LED, 4, number of LEDs (≥2)
- SPEED_LEVELS, 4, number of speed steps (≥1)
- BASE_TICKS, 25_000_000, clk cycles per step at speed 0 (≥2)
- FLASH_TICKS, 12_500_000, cycles of all-on flash after direction change (≥1)
- DB_TICKS, 1_000_000, debounce stability window in cycles (≥1)
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-low
- btn_dir  input  1  direction button, active-low, asynchronous to clk
- btn_speed  input  1  speed button, active-low, asynchronous to clk
- bounce  input  1  0 = wrap motion, 1 = ping-pong motion; sampled every cycle
- led  output  N_LED  LED drive, active-low (0 = lit)
- pos  output  $clog2(N_LED)  index of lit LED
- dir  output  1  0 = ascending index, 1 = descending
- speed  output  $clog2(SPEED_LEVELS) (min 1)  current speed level

## Operation
- **Reset values:** led all 1, pos 0, dir 0, speed 0, tick counter 0, state INIT, button pipelines idle (released).
- **Button front end:** each button produces a one-cycle press pulse on its released→pressed transition. A held button gives exactly one pulse.
- **FSM states:** INIT, RUN, FLASH.
- **INIT:** one cycle with led all 1, then RUN.
- **RUN:**
  - led = one-cold at pos.
  - Tick counter (32 bit) counts 0 … period−1, with period = BASE_TICKS·(speed+1).
  - At period−1 the counter returns to 0 and pos steps by ±1 according to dir.
- **Wrap mode:** ascending N_LED−1 → 0; descending 0 → N_LED−1.
- **Bounce mode:**
  - At an end index, dir inverts and pos moves one toward the interior (N_LED−1 → N_LED−2, 0 → 1).
  - No LED is shown twice in a row.
- **Dir press in RUN:**
  - dir toggles, tick counter clears, pos is held.
  - State goes to FLASH with led all 0.
  - A dir press wins over a step due in the same cycle; that step is discarded.
- **FLASH:**
  - led all 0 for FLASH_TICKS cycles, then RUN at the held pos with the counter at 0.
  - Dir presses are ignored.
- **Speed press (RUN or FLASH):**
  - speed increments, wrapping SPEED_LEVELS−1 → 0.
  - In RUN the tick counter clears; in FLASH the flash timer is unaffected.
- **Simultaneous dir and speed press:** both are applied.
- **Reset asserted mid-operation:** all state returns to reset values on the next edge, regardless of FSM state or pending presses.
- **Arithmetic:** period is computed in 32 bits. Parameters must satisfy BASE_TICKS·SPEED_LEVELS < 2^32; this is checked by an elaboration assertion.

## Timing
- Button-to-pulse latency without debounce: 2-flop sync + edge register, so the pulse appears 3 cycles after the pin is first sampled low.
- Button-to-pulse latency with debounce: 2 + DB_TICKS + 1 cycles; the pin must stay stable for the whole window.
- Pulse-to-effect: registered outputs change on the edge after the pulse cycle.
- Step spacing: exactly BASE_TICKS·(speed+1) cycles between pos changes while in RUN with no presses.
- First step after reset: led shows pos 0 from cycle 1 (INIT is cycle 0); first step occurs period cycles later.

## Configuration
- **LED_CHASER_DEBOUNCE_EN defined:** each button passes through the debounce sub-module. The filtered level changes only after DB_TICKS consecutive identical synchronised samples; glitches shorter than that produce no pulse.
- **LED_CHASER_DEBOUNCE_EN undefined:** 2-flop sync plus edge detect only. DB_TICKS is unused, and every synchronised low-going edge produces a pulse.

## Structure
- **Package led_chaser_pkg:**
  - state enum (INIT, RUN, FLASH);
  - direction constants (DIR_UP = 0, DIR_DOWN = 1);
  - function computing period from speed and BASE_TICKS.
- **Sub-module btn_debounce:** one instance per button. It contains the synchroniser, the optional debounce counter under the macro, and the press-pulse edge detect.

## Test plan
Scenarios 1–4 use N_LED=4, BASE_TICKS=4, FLASH_TICKS=2, DB_TICKS=3, SPEED_LEVELS=4, debounce disabled.
1. Release reset, bounce=0, no buttons → led 1110, 1101, 1011, 0111, 1110 with pos changes every 4 cycles; pos wraps 3 → 0.
2. bounce=1, run 8 steps → pos 0,1,2,3,2,1,0,1; dir 0 → 1 at pos 3 and 1 → 0 at pos 0.
3. Press btn_dir at pos 2 → led 0000 for 2 cycles, then 1011 with dir=1; next pos 1 after 4 cycles. A step due on the pulse cycle is suppressed.
4. Press btn_speed 4 times, 20 cycles apart → speed 1,2,3,0; step spacing 8,12,16,4 cycles; holding the button 50 cycles produces one increment.
5. With LED_CHASER_DEBOUNCE_EN, 2-cycle low glitch on btn_speed → speed unchanged; a 10-cycle press → speed increments once, 6 cycles after the first low sample.
6. Assert reset during FLASH → next edge led 1111, pos 0, dir 0, speed 0, state INIT.
